// File: rtl/state_advance_unit.sv
// Time/state advance stage of the ODE accelerator: on an accepted step it
// advances t (clamped at t_end), copies x_new over x in shared memory and counts steps.
module state_advance_unit #(
  parameter int                WIDTH     = 32,
  parameter int                ADDR_W    = 16,
  parameter int                N_W       = 4,
  parameter logic [ADDR_W-1:0] X_BASE    = 16'h0000,
  parameter logic [ADDR_W-1:0] XNEW_BASE = 16'h0010,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [WIDTH-1:0]  t0_in,
  input  logic [WIDTH-1:0]  tend_in,
  input  logic [N_W-1:0]    n_in,
  input  logic              advance,
  input  logic [WIDTH-1:0]  step_in,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              ready,
  output logic              done,
  output logic              finished,
  output logic              error,
  output logic [WIDTH-1:0]  t_out,
  output logic [WIDTH-1:0]  remaining_out,
  output logic [CNT_W-1:0]  step_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READY    = 3'd1,
    S_ADD_T    = 3'd2,
    S_COPY_RD  = 3'd3,
    S_COPY_WR  = 3'd4,
    S_DONE     = 3'd5,
    S_FINISHED = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   t_r, t_s;
  logic [WIDTH-1:0]   tend_r, tend_s;
  logic [WIDTH-1:0]   h_r, h_s;
  logic [N_W-1:0]     n_r, n_s;
  logic [N_W-1:0]     idx_r, idx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               last_r, last_s;

  logic signed [WIDTH:0] sum_s;
  logic                  ovf_s;
  logic                  h_bad_s;
  logic                  reach_s;
  logic                  last_idx_s;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic [ADDR_W-1:0]     idx_ext_s;

  // Step arithmetic: one extra bit exposes signed overflow of t + h.
  always_comb begin
    sum_s      = {t_r[WIDTH-1], t_r} + {h_r[WIDTH-1], h_r};
    ovf_s      = sum_s[WIDTH] ^ sum_s[WIDTH-1];
    h_bad_s    = h_r[WIDTH-1] | (h_r == {WIDTH{1'b0}});
    reach_s    = sum_s >= $signed({tend_r[WIDTH-1], tend_r});
    last_idx_s = (idx_r == (n_r - {{(N_W-1){1'b0}}, 1'b1}));
    cnt_inc_s  = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
    idx_ext_s  = {{(ADDR_W-N_W){1'b0}}, idx_r};
  end

  // Next-state and datapath update; init overrides everything but rst.
  always_comb begin
    state_s = state_r;
    t_s     = t_r;
    tend_s  = tend_r;
    h_s     = h_r;
    n_s     = n_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    last_s  = last_r;
    if (init) begin
      t_s    = t0_in;
      tend_s = tend_in;
      n_s    = n_in;
      cnt_s  = {CNT_W{1'b0}};
      idx_s  = {N_W{1'b0}};
      last_s = 1'b0;
      if ($signed(tend_in) <= $signed(t0_in)) begin
        state_s = S_FINISHED;
      end else begin
        state_s = S_READY;
      end
    end else begin
      case (state_r)
        S_READY: begin
          if (advance) begin
            h_s     = step_in;
            state_s = S_ADD_T;
          end else begin
            state_s = S_READY;
          end
        end
        S_ADD_T: begin
          if (ovf_s || h_bad_s) begin
            state_s = S_ERROR;
          end else begin
            idx_s  = {N_W{1'b0}};
            last_s = reach_s;
            if (reach_s) begin
              t_s = tend_r;
            end else begin
              t_s = sum_s[WIDTH-1:0];
            end
            // An empty vector commits straight from the add cycle.
            if (n_r == {N_W{1'b0}}) begin
              cnt_s   = cnt_inc_s;
              state_s = reach_s ? S_FINISHED : S_DONE;
            end else begin
              state_s = S_COPY_RD;
            end
          end
        end
        S_COPY_RD: state_s = S_COPY_WR;
        S_COPY_WR: begin
          idx_s = idx_r + {{(N_W-1){1'b0}}, 1'b1};
          if (last_idx_s) begin
            cnt_s   = cnt_inc_s;
            state_s = last_r ? S_FINISHED : S_DONE;
          end else begin
            state_s = S_COPY_RD;
          end
        end
        S_DONE:     state_s = S_READY;
        S_FINISHED: state_s = S_FINISHED;
        S_ERROR:    state_s = S_ERROR;
        S_IDLE:     state_s = S_IDLE;
        default:    state_s = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      t_r     <= {WIDTH{1'b0}};
      tend_r  <= {WIDTH{1'b0}};
      h_r     <= {WIDTH{1'b0}};
      n_r     <= {N_W{1'b0}};
      idx_r   <= {N_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      last_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      t_r     <= t_s;
      tend_r  <= tend_s;
      h_r     <= h_s;
      n_r     <= n_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
    end
  end

  // Moore output decode: strobes and status follow the state register only.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {WIDTH{1'b0}};
    ready     = 1'b0;
    done      = 1'b0;
    finished  = 1'b0;
    error     = 1'b0;
    case (state_r)
      S_READY: ready = 1'b1;
      S_COPY_RD: begin
        mem_rd   = 1'b1;
        mem_addr = XNEW_BASE + idx_ext_s;
      end
      S_COPY_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = X_BASE + idx_ext_s;
        mem_wdata = mem_rdata;
      end
      S_DONE:     done     = 1'b1;
      S_FINISHED: finished = 1'b1;
      S_ERROR:    error    = 1'b1;
      default:    ready    = 1'b0;
    endcase
  end

  assign t_out         = t_r;
  assign step_count    = cnt_r;
  assign remaining_out = (state_r == S_FINISHED) ? {WIDTH{1'b0}} : (tend_r - t_r);

endmodule

// File: tb/tb_state_advance_unit.sv
// Randomized self-checking bench for state_advance_unit against a step-level
// reference model (time arithmetic in longint, expected memory trace per step).
module tb_state_advance_unit;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst, init, advance;
  logic [31:0] t0_in, tend_in, step_in, mem_rdata;
  logic [3:0]  n_in;
  logic        mem_rd, mem_wr, ready, done, finished, error;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, t_out, remaining_out;
  logic [CW-1:0] step_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] xnew [16];
  logic [31:0] xcur [16];

  // model: 0 idle, 1 ready, 2 done, 3 finished, 4 error
  longint m_t, m_tend;
  int     m_n, m_cnt, m_st;

  state_advance_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .init(init), .t0_in(t0_in), .tend_in(tend_in),
    .n_in(n_in), .advance(advance), .step_in(step_in), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ready(ready), .done(done), .finished(finished), .error(error),
    .t_out(t_out), .remaining_out(remaining_out), .step_count(step_count)
  );

  always #5 clk = ~clk;

  // shared memory: x_new at 0x10..0x1F, x at 0x00..0x0F
  always @(posedge clk) begin
    if (mem_rd && mem_addr >= 16'h0010 && mem_addr < 16'h0020) mem_rdata <= xnew[mem_addr[3:0]];
    else mem_rdata <= 32'hDEADBEEF;
    if (mem_wr && mem_addr < 16'h0010) xcur[mem_addr[3:0]] <= mem_wdata;
  end

  function automatic logic [3:0] exp_status(input int st);
    case (st)
      1: return 4'b1000;
      2: return 4'b0100;
      3: return 4'b0010;
      4: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] exp_rem();
    return (m_st == 3) ? 32'h0 : 32'(m_tend - m_t);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_init(input logic [31:0] t0, input logic [31:0] tend, input logic [3:0] n);
    logic [71:0] obs, exp;
    init = 1'b1; t0_in = t0; tend_in = tend; n_in = n;
    tick();
    init = 1'b0; t0_in = $urandom; tend_in = $urandom; n_in = 4'($urandom);
    m_t = longint'($signed(t0)); m_tend = longint'($signed(tend));
    m_n = int'(n); m_cnt = 0; m_st = (m_tend <= m_t) ? 3 : 1;
    obs = {ready, done, finished, error, t_out, step_count, remaining_out};
    exp = {exp_status(m_st), 32'(m_t), 4'(m_cnt), exp_rem()};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL init: got %h want %h", obs, exp);
    end
  endtask

  task automatic do_advance(input logic [31:0] h);
    longint s;
    bit err, last;
    int fin, k;
    logic [49:0] obs_m, exp_m;
    logic [71:0] obs, exp;
    s = m_t + longint'($signed(h));
    err = ($signed(h) <= 0) || (s > 64'sd2147483647) || (s < -64'sd2147483648);
    last = (s >= m_tend);
    fin = err ? 2 : 2 * m_n + 2;
    advance = 1'b1; step_in = h;
    tick();
    advance = 1'b0; step_in = $urandom;
    for (int c = 1; c <= fin; c++) begin
      k = (c - 2) / 2;
      exp_m = '0;
      if (!err && c >= 2 && c <= 2 * m_n + 1) begin
        if (c % 2 == 0) exp_m = {1'b1, 1'b0, 16'(32'h10 + k), 32'h0};
        else exp_m = {1'b0, 1'b1, 16'(k), xnew[k]};
      end
      obs_m = {mem_rd, mem_wr, mem_addr, mem_wdata};
      vectors++;
      if (obs_m !== exp_m) begin
        miscompares++;
        $display("FAIL strobe cycle %0d: got %h want %h", c, obs_m, exp_m);
      end
      if (c < fin) begin
        vectors++;
        if ({ready, done, finished, error} !== 4'b0000) begin
          miscompares++;
          $display("FAIL busy_status cycle %0d: got %b want 0000", c, {ready, done, finished, error});
        end
        tick();
      end
    end
    if (err) m_st = 4;
    else begin
      m_t = last ? m_tend : s;
      m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
      m_st = last ? 3 : 2;
    end
    obs = {ready, done, finished, error, t_out, step_count, remaining_out};
    exp = {exp_status(m_st), 32'(m_t), 4'(m_cnt), exp_rem()};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL step_result h=%h: got %h want %h", h, obs, exp);
    end
    if (m_st == 2) begin
      tick();
      m_st = 1;
      vectors++;
      if ({ready, done, finished, error} !== 4'b1000) begin
        miscompares++;
        $display("FAIL ready_after_done: got %b want 1000", {ready, done, finished, error});
      end
    end
  endtask

  task automatic check_idle_cycles(input int cycles, input logic hold);
    logic [89:0] obs, exp;
    for (int i = 0; i < cycles; i++) begin
      advance = hold; step_in = $urandom_range(1, 32'hFFFF);
      tick();
      obs = {mem_rd, mem_wr, mem_addr, mem_wdata, ready, done, finished, error, t_out, step_count};
      exp = {50'h0, exp_status(m_st), 32'(m_t), 4'(m_cnt)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL idle_hold cycle %0d: got %h want %h", i, obs, exp);
      end
    end
    advance = 1'b0;
  endtask

  task automatic test_reset();
    logic [121:0] obs;
    rst = 1'b1; init = 1'b0; advance = 1'b0;
    t0_in = 32'h0; tend_in = 32'h0; n_in = 4'h0; step_in = 32'h0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      obs = {mem_rd, mem_wr, mem_addr, mem_wdata, ready, done, finished, error,
             t_out, remaining_out, step_count};
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs %0d: got %h want 0", i, obs);
      end
      rst = 1'b0;
      tick();
    end
    m_t = 0; m_tend = 0; m_n = 0; m_cnt = 0; m_st = 0;
  endtask

  task automatic test_basic();
    xnew[0] = 32'h11; xnew[1] = 32'h22; xnew[2] = 32'h33;
    do_init(32'h0, 32'h0001_0000, 4'd3);
    do_advance(32'h0000_4000);
    vectors++;
    if ({t_out, remaining_out, step_count} !== {32'h4000, 32'hC000, 4'd1}) begin
      miscompares++;
      $display("FAIL basic_values: got %h want %h", {t_out, remaining_out, step_count},
               {32'h4000, 32'hC000, 4'd1});
    end
    vectors++;
    if ({xcur[0], xcur[1], xcur[2]} !== {32'h11, 32'h22, 32'h33}) begin
      miscompares++;
      $display("FAIL basic_copy: got %h want 000000110000002200000033", {xcur[0], xcur[1], xcur[2]});
    end
  endtask

  task automatic test_clamp();
    do_advance(32'h4000);
    do_advance(32'h4000);
    do_advance(32'h8000);
    vectors++;
    if ({t_out, finished, done, remaining_out} !== {32'h0001_0000, 1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL clamp: got %h want %h", {t_out, finished, done, remaining_out},
               {32'h0001_0000, 1'b1, 1'b0, 32'h0});
    end
    check_idle_cycles(4, 1'b1);
  endtask

  task automatic test_n0();
    do_init(32'h0, 32'h0001_0000, 4'd0);
    do_advance(32'h4000);
    vectors++;
    if (step_count !== 4'd1) begin
      miscompares++;
      $display("FAIL n0_count: got %0d want 1", step_count);
    end
  endtask

  task automatic test_overflow();
    do_init(32'h7FFF_0000, 32'h7FFF_FFFF, 4'd2);
    do_advance(32'h0002_0000);
    vectors++;
    if ({error, t_out} !== {1'b1, 32'h7FFF_0000}) begin
      miscompares++;
      $display("FAIL overflow: got %h want 17fff0000", {error, t_out});
    end
    check_idle_cycles(3, 1'b1);
    do_init(32'h0, 32'h0001_0000, 4'd2);
    do_advance(32'h0);
    do_init(32'h0, 32'h0001_0000, 4'd2);
    do_advance(32'hFFFF_FFFB);
    do_init(32'h100, 32'h0001_0000, 4'd1);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 16; i++) xnew[i] = $urandom;
    do_init(32'h0, 32'h0010_0000, 4'd4);
    advance = 1'b1; step_in = 32'h1000;
    tick();
    advance = 1'b0;
    tick(); tick(); tick(); tick();
    vectors++;
    if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'h0001, xnew[1]}) begin
      miscompares++;
      $display("FAIL abort_second_write: got %h want %h", {mem_wr, mem_addr, mem_wdata},
               {1'b1, 16'h0001, xnew[1]});
    end
    do_init(32'h2000, 32'h0009_0000, 4'd2);
    check_idle_cycles(3, 1'b0);
    do_advance(32'h3000);
  endtask

  task automatic test_reset_mid_copy();
    do_init(32'h0, 32'h0001_0000, 4'd3);
    advance = 1'b1; step_in = 32'h100;
    tick();
    advance = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({mem_rd, mem_wr, ready, t_out, step_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_copy: got %h want 0", {mem_rd, mem_wr, ready, t_out, step_count});
    end
    m_t = 0; m_tend = 0; m_cnt = 0; m_st = 0;
    check_idle_cycles(2, 1'b1);
  endtask

  task automatic test_saturate();
    do_init(32'h0, 32'h7FFF_0000, 4'd0);
    for (int i = 0; i < 18; i++) do_advance(32'h1);
    vectors++;
    if (step_count !== 4'hF) begin
      miscompares++;
      $display("FAIL saturate: got %h want f", step_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] t0, tend, h;
    logic [3:0] n;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 16; i++) xnew[i] = $urandom;
      n = 4'($urandom_range(0, 15));
      if (it % 5 == 4) begin
        t0 = 32'h7FF0_0000 + $urandom_range(0, 32'hFFFFF);
        tend = 32'h7FFF_FFFF;
      end else begin
        t0 = $urandom_range(0, 32'h10_0000) - 32'h8_0000;
        tend = t0 + ((it % 7 == 3) ? 32'h0 : $urandom_range(1, 32'h6_0000));
      end
      do_init(t0, tend, n);
      for (int s = 0; s < 8 && m_st == 1; s++) begin
        if ($urandom_range(0, 15) == 0) h = 32'h0 - $urandom_range(0, 32'h1000);
        else if (it % 5 == 4) h = $urandom_range(1, 32'h30_0000);
        else h = $urandom_range(1, 32'h3_0000);
        do_advance(h);
        if (m_st != 4) begin
          for (int k = 0; k < m_n; k++) begin
            vectors++;
            if (xcur[k] !== xnew[k]) begin
              miscompares++;
              $display("FAIL random_copy word %0d: got %h want %h", k, xcur[k], xnew[k]);
            end
          end
        end
      end
      if (m_st != 1) check_idle_cycles(2, 1'b1);
    end
  endtask

  task automatic test_degenerate();
    logic [121:0] obs;
    do_init(32'h5000, 32'h5000, 4'd3);
    check_idle_cycles(3, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs = {mem_rd, mem_wr, mem_addr, mem_wdata, ready, done, finished, error,
           t_out, remaining_out, step_count};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL degenerate_reset: got %h want 0", obs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_n0();
    test_overflow();
    test_abort();
    test_reset_mid_copy();
    test_saturate();
    test_random();
    test_degenerate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
